alu_arbiter: RTL and testbench

- Shares the single combinational `alu` instance between two requesters: port 0 = execute stage, port 1 = auxiliary (address generation / CSR update).
- Arbitrates, registers the selected operation onto the ALU inputs, captures the ALU result and returns it with a valid/ready response handshake.
- Sits between the core pipeline and the `alu` instance; it is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter that shares one combinational ALU between the execute stage (port 0)
// and the auxiliary requester (port 1), with registered ALU inputs and a held result.
module alu_arbiter #(
  parameter int unsigned M_WIDTH    = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_funct3,
  input  logic               req0_modifier,
  input  logic [M_WIDTH-1:0] req0_in1,
  input  logic [M_WIDTH-1:0] req0_in2,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [M_WIDTH-1:0] resp0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_funct3,
  input  logic               req1_modifier,
  input  logic [M_WIDTH-1:0] req1_in1,
  input  logic [M_WIDTH-1:0] req1_in2,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [M_WIDTH-1:0] resp1_data,
  output logic [2:0]         alu_funct3,
  output logic               alu_modifier,
  output logic [M_WIDTH-1:0] alu_in1,
  output logic [M_WIDTH-1:0] alu_in2,
  input  logic [M_WIDTH-1:0] alu_out
);

  localparam int unsigned F3_W  = 3;
  localparam bit          FIXED = (FIXED_PRIO != 0);

  typedef struct packed {
    logic [F3_W-1:0]    funct3;
    logic               modifier;
    logic [M_WIDTH-1:0] in1;
    logic [M_WIDTH-1:0] in2;
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  op_t                op_q, op_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [M_WIDTH-1:0] result_q, result_d;

  logic win0, win1, accept, resp_hs;
  op_t  req0_op, req1_op;

  assign req0_op = '{funct3: req0_funct3, modifier: req0_modifier, in1: req0_in1, in2: req0_in2};
  assign req1_op = '{funct3: req1_funct3, modifier: req1_modifier, in1: req1_in1, in2: req1_in2};

  // Winner selection: a lone requester wins; on a tie, fixed priority or the port not served last.
  always_comb begin
    win0    = req0_valid & (~req1_valid | FIXED | last_grant_q);
    win1    = req1_valid & ~win0;
    accept  = (state_q == IDLE) & (win0 | win1);
    resp_hs = (state_q == RESP) & (grant_q ? resp1_ready : resp0_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is offered only while idle; the response is steered to the granted port alone.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_data  = '0;
    resp1_data  = '0;
    if (state_q == IDLE) begin
      req0_ready = win0;
      req1_ready = win1;
    end
    if (state_q == RESP) begin
      if (grant_q) begin
        resp1_valid = 1'b1;
        resp1_data  = result_q;
      end else begin
        resp0_valid = 1'b1;
        resp0_data  = result_q;
      end
    end
  end

  // Operation is sampled on the accept edge; the ALU result is captured after one stable cycle.
  always_comb begin
    op_d         = op_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    if (accept) begin
      op_d    = win1 ? req1_op : req0_op;
      grant_d = win1;
    end
    if (state_q == EXEC) begin
      result_d = alu_out;
    end
    if (resp_hs) begin
      last_grant_d = grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      op_q         <= op_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

  assign alu_funct3   = op_q.funct3;
  assign alu_modifier = op_q.modifier;
  assign alu_in1      = op_q.in1;
  assign alu_in2      = op_q.in2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance checked every cycle against a transaction model,
// and a fixed-priority instance checked for port 0 dominance.
module tb_alu_arbiter;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Round-robin instance signals
  logic         a_req0_valid, a_req0_ready, a_req0_modifier, a_resp0_valid, a_resp0_ready;
  logic [2:0]   a_req0_funct3;
  logic [W-1:0] a_req0_in1, a_req0_in2, a_resp0_data;
  logic         a_req1_valid, a_req1_ready, a_req1_modifier, a_resp1_valid, a_resp1_ready;
  logic [2:0]   a_req1_funct3;
  logic [W-1:0] a_req1_in1, a_req1_in2, a_resp1_data;
  logic [2:0]   a_alu_funct3;
  logic         a_alu_modifier;
  logic [W-1:0] a_alu_in1, a_alu_in2, a_alu_out;

  // Fixed-priority instance signals
  logic         b_req0_valid, b_req0_ready, b_req0_modifier, b_resp0_valid, b_resp0_ready;
  logic [2:0]   b_req0_funct3;
  logic [W-1:0] b_req0_in1, b_req0_in2, b_resp0_data;
  logic         b_req1_valid, b_req1_ready, b_req1_modifier, b_resp1_valid, b_resp1_ready;
  logic [2:0]   b_req1_funct3;
  logic [W-1:0] b_req1_in1, b_req1_in2, b_resp1_data;
  logic [2:0]   b_alu_funct3;
  logic         b_alu_modifier;
  logic [W-1:0] b_alu_in1, b_alu_in2, b_alu_out;

  // Reference ALU (RISC-V style funct3 encoding)
  function automatic logic [W-1:0] alu_ref(input logic [2:0] f, input logic m,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2:0] sh;
    sh = y[2:0];
    case (f)
      3'd0:    return m ? W'(x - y) : W'(x + y);
      3'd1:    return W'(x << sh);
      3'd2:    return {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      3'd3:    return {{(W-1){1'b0}}, (x < y)};
      3'd4:    return x ^ y;
      3'd5:    return m ? W'($signed(x) >>> sh) : W'(x >> sh);
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  assign a_alu_out = alu_ref(a_alu_funct3, a_alu_modifier, a_alu_in1, a_alu_in2);
  assign b_alu_out = alu_ref(b_alu_funct3, b_alu_modifier, b_alu_in1, b_alu_in2);

  alu_arbiter #(.M_WIDTH(W), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_funct3(a_req0_funct3),
    .req0_modifier(a_req0_modifier), .req0_in1(a_req0_in1), .req0_in2(a_req0_in2),
    .resp0_valid(a_resp0_valid), .resp0_ready(a_resp0_ready), .resp0_data(a_resp0_data),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_funct3(a_req1_funct3),
    .req1_modifier(a_req1_modifier), .req1_in1(a_req1_in1), .req1_in2(a_req1_in2),
    .resp1_valid(a_resp1_valid), .resp1_ready(a_resp1_ready), .resp1_data(a_resp1_data),
    .alu_funct3(a_alu_funct3), .alu_modifier(a_alu_modifier),
    .alu_in1(a_alu_in1), .alu_in2(a_alu_in2), .alu_out(a_alu_out)
  );

  alu_arbiter #(.M_WIDTH(W), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_funct3(b_req0_funct3),
    .req0_modifier(b_req0_modifier), .req0_in1(b_req0_in1), .req0_in2(b_req0_in2),
    .resp0_valid(b_resp0_valid), .resp0_ready(b_resp0_ready), .resp0_data(b_resp0_data),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_funct3(b_req1_funct3),
    .req1_modifier(b_req1_modifier), .req1_in1(b_req1_in1), .req1_in2(b_req1_in2),
    .resp1_valid(b_resp1_valid), .resp1_ready(b_resp1_ready), .resp1_data(b_resp1_data),
    .alu_funct3(b_alu_funct3), .alu_modifier(b_alu_modifier),
    .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_out(b_alu_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: one op in flight, its result is valid from two cycles after acceptance.
  bit           m_busy = 1'b0;
  int           m_age  = 0;
  bit           m_port = 1'b0;
  bit           m_last = 1'b1;
  logic [W-1:0] m_res  = '0;
  logic         e_r0, e_r1, e_v0, e_v1;
  bit           g_log[$];
  logic [W:0]   d_log[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_handshake_outs", {28'd0, a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid}, 32'd0);
      chk("reset_data_outs", {a_resp0_data, a_resp1_data, a_alu_in1, a_alu_in2}, 32'd0);
      chk("reset_alu_ctrl", {28'd0, a_alu_funct3, a_alu_modifier}, 32'd0);
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
    end else begin
      e_r0 = !m_busy && a_req0_valid && (!a_req1_valid || m_last);
      e_r1 = !m_busy && a_req1_valid && !e_r0;
      e_v0 = m_busy && m_age >= 2 && !m_port;
      e_v1 = m_busy && m_age >= 2 && m_port;
      chk("req0_ready", 32'(a_req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(a_req1_ready), 32'(e_r1));
      chk("resp0_valid", 32'(a_resp0_valid), 32'(e_v0));
      chk("resp1_valid", 32'(a_resp1_valid), 32'(e_v1));
      chk("resp0_data", 32'(a_resp0_data), e_v0 ? 32'(m_res) : 32'd0);
      chk("resp1_data", 32'(a_resp1_data), e_v1 ? 32'(m_res) : 32'd0);
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_busy = 1'b1;
          m_age  = 0;
          m_port = e_r1;
          m_res  = e_r1 ? alu_ref(a_req1_funct3, a_req1_modifier, a_req1_in1, a_req1_in2)
                        : alu_ref(a_req0_funct3, a_req0_modifier, a_req0_in1, a_req0_in2);
          g_log.push_back(m_port);
        end
      end else if (m_age >= 2) begin
        if (m_port ? a_resp1_ready : a_resp0_ready) begin
          d_log.push_back({m_port, m_port ? a_resp1_data : a_resp0_data});
          m_last = m_port;
          m_busy = 1'b0;
        end
      end
      if (m_busy) m_age++;
    end
  end

  // One complete operation on the round-robin instance, response consumed as soon as valid.
  task automatic do_op(input bit p, input logic [2:0] f, input logic m, input logic [W-1:0] x,
                       input logic [W-1:0] y, output logic [W-1:0] d, output int lat);
    int n;
    @(posedge clk); #1;
    if (!p) begin
      a_req0_funct3 = f; a_req0_modifier = m; a_req0_in1 = x; a_req0_in2 = y;
      a_req0_valid = 1'b1; a_resp0_ready = 1'b1;
    end else begin
      a_req1_funct3 = f; a_req1_modifier = m; a_req1_in1 = x; a_req1_in2 = y;
      a_req1_valid = 1'b1; a_resp1_ready = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(p ? a_req1_ready : a_req0_ready) && n < 20) begin n++; @(negedge clk); end
    chk("op_ready_seen", 32'(p ? a_req1_ready : a_req0_ready), 32'd1);
    @(posedge clk); #1;
    if (!p) a_req0_valid = 1'b0; else a_req1_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(p ? a_resp1_valid : a_resp0_valid) && lat < 20) begin lat++; @(negedge clk); end
    d = p ? a_resp1_data : a_resp0_data;
    @(posedge clk); #1;
    if (!p) a_resp0_ready = 1'b0; else a_resp1_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    int           lat, gb, db, n, cnt0, nlog;
    a_req0_valid = 0; a_req0_funct3 = 0; a_req0_modifier = 0; a_req0_in1 = 0; a_req0_in2 = 0;
    a_req1_valid = 0; a_req1_funct3 = 0; a_req1_modifier = 0; a_req1_in1 = 0; a_req1_in2 = 0;
    a_resp0_ready = 0; a_resp1_ready = 0;
    b_req0_valid = 0; b_req0_funct3 = 3'd4; b_req0_modifier = 0; b_req0_in1 = 8'hF0; b_req0_in2 = 8'h0F;
    b_req1_valid = 0; b_req1_funct3 = 3'd7; b_req1_modifier = 0; b_req1_in1 = 8'hF0; b_req1_in2 = 8'h0F;
    b_resp0_ready = 1; b_resp1_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_reset_idle", {28'd0, a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid}, 32'd0);

    do_op(1'b0, 3'd0, 1'b0, 8'h05, 8'h03, d, lat);
    chk("add_data", 32'(d), 32'h08);
    chk("add_latency", 32'(lat), 32'd2);
    do_op(1'b1, 3'd0, 1'b1, 8'h05, 8'h07, d, lat);
    chk("sub_data", 32'(d), 32'hFE);
    do_op(1'b1, 3'd5, 1'b1, 8'h80, 8'h02, d, lat);
    chk("sra_data", 32'(d), 32'hE0);
    chk("sra_latency", 32'(lat), 32'd2);

    // Both ports valid every cycle: grants must alternate starting with port 0
    gb = g_log.size();
    db = d_log.size();
    @(posedge clk); #1;
    a_req0_funct3 = 3'd4; a_req0_modifier = 0; a_req0_in1 = 8'hF0; a_req0_in2 = 8'h0F;
    a_req1_funct3 = 3'd7; a_req1_modifier = 0; a_req1_in1 = 8'hF0; a_req1_in2 = 8'h0F;
    a_req0_valid = 1; a_req1_valid = 1; a_resp0_ready = 1; a_resp1_ready = 1;
    repeat (12) @(posedge clk);
    #1 a_req0_valid = 0; a_req1_valid = 0;
    repeat (4) @(posedge clk);
    #1 a_resp0_ready = 0; a_resp1_ready = 0;
    chk("rr_grant_count", 32'(g_log.size() - gb), 32'd4);
    chk("rr_resp_count", 32'(d_log.size() - db), 32'd4);
    if (g_log.size() >= gb + 4 && d_log.size() >= db + 4) begin
      chk("rr_grant_seq", {28'd0, g_log[gb], g_log[gb+1], g_log[gb+2], g_log[gb+3]}, 32'b0101);
      chk("rr_resp_a", 32'(d_log[db]),   32'h0FF);
      chk("rr_resp_b", 32'(d_log[db+1]), 32'h100);
      chk("rr_resp_c", 32'(d_log[db+2]), 32'h0FF);
      chk("rr_resp_d", 32'(d_log[db+3]), 32'h100);
    end

    // Backpressure on port 0 with port 1 waiting
    @(posedge clk); #1;
    a_req0_funct3 = 3'd0; a_req0_modifier = 0; a_req0_in1 = 8'h10; a_req0_in2 = 8'h20;
    a_req0_valid = 1;
    n = 0;
    @(negedge clk);
    while (!a_req0_ready && n < 20) begin n++; @(negedge clk); end
    chk("bp_req0_ready", 32'(a_req0_ready), 32'd1);
    @(posedge clk); #1;
    a_req0_valid = 0;
    a_req1_funct3 = 3'd6; a_req1_modifier = 0; a_req1_in1 = 8'h0C; a_req1_in2 = 8'h03;
    a_req1_valid = 1; a_resp1_ready = 1;
    n = 0;
    @(negedge clk);
    while (!a_resp0_valid && n < 20) begin n++; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(a_resp0_valid), 32'd1);
      chk("bp_hold_data", 32'(a_resp0_data), 32'h30);
      chk("bp_req1_blocked", 32'(a_req1_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 a_resp0_ready = 1;
    @(negedge clk);
    chk("bp_hs_req1_blocked", 32'(a_req1_ready), 32'd0);
    @(posedge clk); #1 a_resp0_ready = 0;
    @(negedge clk);
    chk("bp_req1_served_next", 32'(a_req1_ready), 32'd1);
    @(posedge clk); #1 a_req1_valid = 0;
    repeat (4) @(posedge clk);
    #1 a_resp1_ready = 0;
    chk("bp_port1_result", 32'(d_log[d_log.size()-1]), 32'h10F);

    // Reset while the ALU operation is in flight
    @(posedge clk); #1;
    a_req0_funct3 = 3'd0; a_req0_modifier = 0; a_req0_in1 = 8'h33; a_req0_in2 = 8'h44;
    a_req0_valid = 1; a_resp0_ready = 1;
    n = 0;
    @(negedge clk);
    while (!a_req0_ready && n < 20) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    a_req0_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst_exec_alu_in", {16'd0, a_alu_in1, a_alu_in2}, 32'd0);
    chk("rst_exec_ctrl", {26'd0, a_alu_funct3, a_alu_modifier, a_resp0_valid, a_req0_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    nlog = d_log.size();
    repeat (5) @(posedge clk);
    #1 chk("rst_no_response", 32'(d_log.size()), 32'(nlog));
    do_op(1'b0, 3'd0, 1'b0, 8'h01, 8'h01, d, lat);
    chk("post_rst_add", 32'(d), 32'h02);

    // Fixed priority: port 1 starves while port 0 stays valid
    cnt0 = 0;
    @(posedge clk); #1 b_req0_valid = 1; b_req1_valid = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("fp_req1_blocked", 32'(b_req1_ready), 32'd0);
      if (b_resp0_valid) begin
        cnt0++;
        chk("fp_resp0_data", 32'(b_resp0_data), 32'hFF);
      end
    end
    chk("fp_port0_count", 32'(cnt0), 32'd8);
    @(posedge clk); #1 b_req0_valid = 0;
    n = 0;
    @(negedge clk);
    while (!b_resp1_valid && n < 10) begin n++; @(negedge clk); end
    chk("fp_port1_valid", 32'(b_resp1_valid), 32'd1);
    chk("fp_port1_data", 32'(b_resp1_data), 32'h00);
    @(posedge clk); #1 b_req1_valid = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
